rr_grant_scanner: RTL

Four-channel round-robin grant sequencer that drives the 2-to-4 active-low decoder stage. It arbitrates among four request lines and presents the winner as a 2-bit select plus an active-low enable. The decoder turns these into one-hot active-low grant strobes. Grants are bounded by a hold timeout and separated by a one-cycle dead gap, so two decoder outputs never change in the same cycle.

---
 rtl/rr_grant_scanner.sv | 117 +++++++++++
 1 files changed

// File: rtl/rr_grant_scanner.sv
// Four-channel round-robin grant sequencer feeding a 2-to-4 active-low decoder.
// Grants are hold-limited and always separated by a one-cycle dead gap.
module rr_grant_scanner #(
  parameter int MAX_HOLD = 15,
  parameter int HOLD_W   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  input  logic       i_release,
  output logic [1:0] o_sel,
  output logic       o_en_n,
  output logic       o_busy,
  output logic       o_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            r_state;
  logic [1:0]        r_sel;
  logic              r_enN;
  logic              r_busy;
  logic              r_timeout;
  logic [1:0]        r_ptr;
  logic [HOLD_W-1:0] r_holdCnt;

  state_t            w_nextState;
  logic [1:0]        w_nextSel;
  logic              w_nextEnN;
  logic              w_nextBusy;
  logic              w_nextTimeout;
  logic [1:0]        w_nextPtr;
  logic [HOLD_W-1:0] w_nextHoldCnt;
  logic [1:0]        w_winner;
  logic              w_expired;
  logic              w_dropped;

  // Scan downward so the channel closest to r_ptr is written last and wins.
  always_comb begin
    w_winner = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (i_req[r_ptr + 2'(k)]) begin
        w_winner = r_ptr + 2'(k);
      end
    end
  end

  assign w_expired = (r_holdCnt == HOLD_W'(MAX_HOLD - 1));
  assign w_dropped = ~i_req[r_sel];

  always_comb begin
    w_nextState   = r_state;
    w_nextSel     = r_sel;
    w_nextEnN     = r_enN;
    w_nextBusy    = r_busy;
    w_nextTimeout = 1'b0;
    w_nextPtr     = r_ptr;
    w_nextHoldCnt = r_holdCnt;
    case (r_state)
      GRANT: begin
        if (i_release || w_dropped || w_expired) begin
          w_nextEnN     = 1'b1;
          w_nextBusy    = 1'b0;
          w_nextPtr     = r_sel + 2'd1;
          w_nextState   = GAP;
          w_nextTimeout = ~i_release & ~w_dropped;
        end else begin
          w_nextHoldCnt = r_holdCnt + 1'b1;
        end
      end
      default: begin
        // IDLE and GAP arbitrate identically; GAP has already advanced r_ptr.
        if (i_req != 4'b0000) begin
          w_nextSel     = w_winner;
          w_nextEnN     = 1'b0;
          w_nextBusy    = 1'b1;
          w_nextHoldCnt = '0;
          w_nextState   = GRANT;
        end else begin
          w_nextEnN   = 1'b1;
          w_nextBusy  = 1'b0;
          w_nextState = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_sel     <= 2'b00;
      r_enN     <= 1'b1;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_ptr     <= 2'b00;
      r_holdCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_sel     <= w_nextSel;
      r_enN     <= w_nextEnN;
      r_busy    <= w_nextBusy;
      r_timeout <= w_nextTimeout;
      r_ptr     <= w_nextPtr;
      r_holdCnt <= w_nextHoldCnt;
    end
  end

  assign o_sel     = r_sel;
  assign o_en_n    = r_enN;
  assign o_busy    = r_busy;
  assign o_timeout = r_timeout;

endmodule
